// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, engine FSM states and default datapath width.
package alu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_RSVD = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_BNE  = 4'b0110;
  localparam logic [3:0] OP_MFLO = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULT = 4'b1101;
  localparam logic [3:0] OP_MFHI = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;
  typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_e;
  function automatic logic is_iter(input logic [3:0] op);
    return op == OP_MULT || op == OP_MUL || op == OP_DIV;
  endfunction
endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative signed mult/mul/div engine on magnitudes, owning HI/LO.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         mul_wr,
  output logic [W-1:0] mul_val,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  localparam int CW = $clog2(W);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0] op_q;
  logic [W-1:0] a_q, b_q, hi_q, lo_q, rnew, quo, rem;
  logic [2*W-1:0] acc_q, acc_d, m_next, d_next, prod;
  logic [W:0] sum;
  logic neg_q, nega_q, div0_q, last, ge;
  assign last = state_q == ITER && cnt_q == '0;
  always_comb begin
    state_d = state_q == IDLE ? (start ? LOAD : IDLE) :
              state_q == LOAD ? ITER :
              state_q == ITER ? (last ? FIX : ITER) : IDLE;
  end
  // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div
  assign sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, acc_q[0] ? b_q : '0};
  assign m_next = {sum, acc_q[W-1:1]};
  assign ge     = acc_q[2*W-1:W-1] >= {1'b0, b_q};
  assign rnew   = acc_q[2*W-2:W-1] - b_q;
  assign d_next = ge ? {rnew, acc_q[W-2:0], 1'b1} : {acc_q[2*W-2:0], 1'b0};
  assign acc_d  = op_q == OP_DIV ? d_next : m_next;
  // sign fix-up folded into the last iteration so HI/LO/result are valid while in FIX
  assign prod   = neg_q ? -acc_d : acc_d;
  assign quo    = neg_q && !div0_q ? -acc_d[W-1:0] : acc_d[W-1:0];
  assign rem    = nega_q ? -acc_d[2*W-1:W] : acc_d[2*W-1:W];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      nega_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
      if (state_q == LOAD) begin
        acc_q  <= {{W{1'b0}}, (a_q[W-1] ? -a_q : a_q)};
        b_q    <= b_q[W-1] ? -b_q : b_q;
        neg_q  <= a_q[W-1] ^ b_q[W-1];
        nega_q <= a_q[W-1];
        div0_q <= b_q == '0;
        cnt_q  <= CW'(W - 1);
      end
      if (state_q == ITER) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q - CW'(1);
      end
      if (last && op_q == OP_MULT) {hi_q, lo_q} <= prod;
      if (last && op_q == OP_DIV) begin
        hi_q <= rem;
        lo_q <= quo;
      end
    end
  end
  assign busy    = state_q != IDLE;
  assign done    = state_q == FIX;
  assign mul_wr  = last && op_q == OP_MUL;
  assign mul_val = prod[W-1:0];
  assign hi      = hi_q;
  assign lo      = lo_q;
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU executing 4-bit control codes; 1-cycle ops plus an
// iterative mult/mul/div engine with HI/LO when ALU_MULDIV_EN is defined.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              branch_cond,
  output logic              ill_op
);
  logic accept, go_iter, unsup, hold, bc_val, done_q, ill_q, bc_q, eng_busy, eng_done, mul_wr;
  logic [DATA_W-1:0] result_q, alu_res, hi, lo, mul_val;
`ifdef ALU_MULDIV_EN
  assign go_iter = is_iter(alu_ctrl);
  assign unsup   = alu_ctrl == OP_RSVD;
  alu_muldiv_seq #(.W(DATA_W)) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && go_iter),
    .op      (alu_ctrl),
    .a       (a),
    .b       (b),
    .busy    (eng_busy),
    .done    (eng_done),
    .mul_wr  (mul_wr),
    .mul_val (mul_val),
    .hi      (hi),
    .lo      (lo)
  );
`else
  assign go_iter = 1'b0;
  assign unsup   = alu_ctrl == OP_RSVD || is_iter(alu_ctrl);
  assign {eng_busy, eng_done, mul_wr} = '0;
  assign mul_val = '0;
  assign hi      = '0;
  assign lo      = '0;
`endif
  assign ready  = !eng_busy;
  assign accept = start && ready;
  assign hold   = unsup || go_iter || alu_ctrl == OP_NOP;
  always_comb begin
    alu_res = result_q;
    bc_val  = 1'b0;
    case (alu_ctrl)
      OP_ADD:  alu_res = a + b;
      OP_BEQ:  begin alu_res = a - b; bc_val = a == b; end
      OP_BNE:  begin alu_res = a - b; bc_val = a != b; end
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      bc_q     <= 1'b0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      done_q <= accept && !go_iter;
      ill_q  <= accept && unsup;
      if (accept && !hold) result_q <= alu_res;
      else if (mul_wr) result_q <= mul_val;
      if (accept && alu_ctrl != OP_NOP) bc_q <= bc_val;
    end
  end
  assign done        = done_q || eng_done;
  assign result      = result_q;
  assign branch_cond = bc_q;
  assign ill_op      = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed scoreboard bench for alu_exec_unit; iterative-engine
// expectations are selected by ALU_MULDIV_EN.
module tb_alu_exec_unit;
  import alu_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] alu_ctrl = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0] shamt = '0;
  logic ready, done, branch_cond, ill_op;
  logic [31:0] result;
  typedef struct {logic [31:0] res; logic bc; logic ill;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  alu_exec_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .alu_ctrl    (alu_ctrl),
    .a           (a),
    .b           (b),
    .shamt       (shamt),
    .ready       (ready),
    .done        (done),
    .result      (result),
    .branch_cond (branch_cond),
    .ill_op      (ill_op)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_bc"}, branch_cond, 0);
    check({tag, "_ill"}, ill_op, 0);
  endtask
  task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [4:0] s, input logic [31:0] er, input logic ebc,
                      input logic eill, input bit keep);
    start = 1'b1; alu_ctrl = op; a = x; b = y; shamt = s;
    sb.push_back('{er, ebc, eill});
    @(posedge clk); #1;
    if (!keep) begin
      start = 1'b0; a = $urandom; b = $urandom; shamt = 5'($urandom);
    end
  endtask
  task automatic collect(input string tag, input int budget, input bit poke, output int lat);
    exp_t e;
    int n = 0;
    bit rdy_bad = 0;
    if (poke) begin start = 1'b1; alu_ctrl = OP_ADD; a = 32'd1; b = 32'd1; end
    while (done !== 1'b1 && n < budget) begin
      if (poke && ready !== 1'b0) rdy_bad = 1;
      @(posedge clk); #1;
      n++;
    end
    if (poke) begin
      if (ready !== 1'b0) rdy_bad = 1;
      start = 1'b0;
      check({tag, "_ready_low"}, rdy_bad, 0);
    end
    lat = n + 1;
    check({tag, "_done"}, done, 1);
    if (done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, result, e.res);
      check({tag, "_bc"}, branch_cond, e.bc);
      check({tag, "_ill"}, ill_op, e.ill);
    end
  endtask
  initial begin
    logic [31:0] x, y;
    int lat;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    reset = 1'b0;
    send(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 0, 0, 0); collect("add_ovf", 0, 0, lat);
    check("add_latency", lat, 1);
    send(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 0, 0, 0);        collect("slt", 2, 0, lat);
    send(OP_SRL, 32'd0, 32'h8000_0000, 5'd31, 32'd1, 0, 0, 0);       collect("srl", 2, 0, lat);
    send(OP_NOR, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);        collect("nor", 2, 0, lat);
    send(OP_SLL, 32'd0, 32'd3, 5'd4, 32'h30, 0, 0, 0);               collect("sll", 2, 0, lat);
    send(OP_AND, 32'hF0F0, 32'hFF00, 5'd0, 32'hF000, 0, 0, 0);       collect("and", 2, 0, lat);
    send(OP_OR, 32'hF0F0, 32'hFF00, 5'd0, 32'hFFF0, 0, 0, 0);        collect("or", 2, 0, lat);
    x = $urandom; y = $urandom;
    send(OP_BEQ, x, y, 5'd0, x - y, x == y, 0, 0);                   collect("sub_rand", 2, 0, lat);
    send(OP_BEQ, 32'd5, 32'd5, 5'd0, 32'd0, 1, 0, 0);                collect("beq", 2, 0, lat);
    send(OP_NOP, 32'd9, 32'd9, 5'd0, 32'd0, 1, 0, 0);                collect("nop_hold", 2, 0, lat);
    send(OP_BNE, 32'd5, 32'd5, 5'd0, 32'd0, 0, 0, 0);                collect("bne", 2, 0, lat);
    send(OP_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 0, 0, 0);                collect("add_after_br", 2, 0, lat);
    send(OP_RSVD, 32'd7, 32'd7, 5'd0, 32'd5, 0, 1, 0);               collect("rsvd", 2, 0, lat);
    send(OP_ADD, 32'd1, 32'd2, 5'd0, 32'd3, 0, 0, 1);                collect("b2b_0", 0, 0, lat);
    send(OP_OR, 32'd4, 32'd1, 5'd0, 32'd5, 0, 0, 1);                 collect("b2b_1", 0, 0, lat);
    send(OP_BNE, 32'd9, 32'd4, 5'd0, 32'd5, 1, 0, 0);                collect("b2b_2", 0, 0, lat);
    @(posedge clk); #1;
    check("b2b_done_drop", done, 0);
`ifdef ALU_MULDIV_EN
    send(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, 32'd5, 0, 0, 0);       collect("mult", 40, 1, lat);
    check("mult_latency", lat, 34);
    @(posedge clk); #1;
    check("mult_no_extra_done", done, 0);
    check("mult_ready_back", ready, 1);
    send(OP_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);       collect("mult_hi", 2, 0, lat);
    send(OP_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFEB, 0, 0, 0);       collect("mult_lo", 2, 0, lat);
    send(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'hFFFF_FFEB, 0, 0, 0); collect("div_neg", 40, 0, lat);
    send(OP_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFD, 0, 0, 0);       collect("div_neg_lo", 2, 0, lat);
    send(OP_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);       collect("div_neg_hi", 2, 0, lat);
    send(OP_DIV, 32'd9, 32'd0, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);        collect("div0", 40, 0, lat);
    send(OP_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);       collect("div0_lo", 2, 0, lat);
    send(OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd9, 0, 0, 0);               collect("div0_hi", 2, 0, lat);
    send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'd9, 0, 0, 0); collect("div_ovf", 40, 0, lat);
    send(OP_MFLO, 32'd0, 32'd0, 5'd0, 32'h8000_0000, 0, 0, 0);       collect("div_ovf_lo", 2, 0, lat);
    send(OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);               collect("div_ovf_hi", 2, 0, lat);
    send(OP_MUL, 32'h1_0000, 32'h1_0000, 5'd0, 32'd0, 0, 0, 0);      collect("mul_wrap", 40, 0, lat);
    send(OP_MFLO, 32'd0, 32'd0, 5'd0, 32'h8000_0000, 0, 0, 0);       collect("mul_lo_kept", 2, 0, lat);
    send(OP_MUL, 32'hFFFF_FFFD, 32'd5, 5'd0, 32'hFFFF_FFF1, 0, 0, 0); collect("mul_neg", 40, 0, lat);
    send(OP_DIV, 32'd9, 32'd0, 5'd0, 32'hFFFF_FFF1, 0, 0, 0);        collect("div_hi_set", 40, 0, lat);
    send(OP_DIV, 32'd100, 32'd7, 5'd0, 32'd0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_mid_div");
    sb.delete();
    reset = 1'b0;
    send(OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);               collect("rst_hi", 2, 0, lat);
    send(OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);               collect("rst_lo", 2, 0, lat);
`else
    send(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, 32'd5, 0, 1, 0);       collect("mult_ill", 0, 0, lat);
    check("mult_ill_latency", lat, 1);
    check("mult_ill_ready", ready, 1);
    send(OP_DIV, 32'd9, 32'd2, 5'd0, 32'd5, 0, 1, 0);                collect("div_ill", 0, 0, lat);
    send(OP_MUL, 32'd3, 32'd3, 5'd0, 32'd5, 0, 1, 0);                collect("mul_ill", 0, 0, lat);
    send(OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);               collect("hi_zero", 2, 0, lat);
    send(OP_ADD, 32'd10, 32'd20, 5'd0, 32'd30, 0, 0, 0);             collect("add_after_ill", 2, 0, lat);
    send(OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 0, 0, 0);               collect("lo_zero", 2, 0, lat);
    send(OP_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 0, 0, 0);                collect("pre_reset", 2, 0, lat);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_late");
    sb.delete();
    reset = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
